// File: rtl/shared_incr_arbiter.sv
// shared_incr_arbiter
//   Round-robin arbiter that puts NUM_REQ requesters onto one incrementer.
//   The single result register sits behind a valid/ready handshake.
//   A granted operand is returned as operand+1 one cycle after the grant,
//   tagged with the index of the requester that supplied it.
//
// Build option:
//   SHARED_INCR_ARBITER_SATURATE_EN
//     defined   : an all-ones operand saturates to all-ones.
//     undefined : an all-ones operand wraps to zero.
//   In both builds o_ovf is set for an all-ones operand.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_req_valid   per-requester operand valid               [NUM_REQ]
//   o_req_ready   one-hot grant, combinational              [NUM_REQ]
//   i_req_data    operands, requester k at [k*WIDTH +: WIDTH]
//   o_resp_valid  the result register holds a result
//   i_resp_ready  the consumer accepts the result
//   o_resp_data   incremented operand                       [WIDTH]
//   o_resp_id     index of the requester that owns the result
//   o_ovf         operand was all-ones (wrapped or saturated)
//
// FSM states:
//   state | meaning
//   EMPTY | result register empty, o_resp_valid = 0
//   FULL  | result register holds a result, o_resp_valid = 1
module shared_incr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [WIDTH-1:0]           o_resp_data,
  output logic [$clog2(NUM_REQ)-1:0] o_resp_id,
  output logic                       o_ovf
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_any;
  logic             slot_free;
  logic             grant;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             ovf;

  // Round-robin search. It starts one past the last winner and wraps at
  // NUM_REQ. The first valid index found wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(last_grant_q) + 1 + i) % NUM_REQ);
      if (!grant_any && i_req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The slot is free when empty, or when the held result leaves this cycle.
  // This lets the arbiter sustain one grant per cycle.
  assign slot_free   = (state_q == EMPTY) || i_resp_ready;
  assign grant       = grant_any && slot_free && !i_rst;
  assign o_req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  assign operand = i_req_data[grant_idx*WIDTH +: WIDTH];
  assign ovf     = &operand;

`ifdef SHARED_INCR_ARBITER_SATURATE_EN
  assign result = ovf ? operand : operand + WIDTH'(1);
`else
  assign result = operand + WIDTH'(1);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL: begin
        if (grant)             state_d = FULL;
        else if (i_resp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= EMPTY;
      o_resp_data  <= '0;
      o_resp_id    <= '0;
      o_ovf        <= 1'b0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      // The result fields change only on a grant. They hold steady in
      // EMPTY and while a FULL result is stalled.
      if (grant) begin
        o_resp_data  <= result;
        o_resp_id    <= grant_idx;
        o_ovf        <= ovf;
        last_grant_q <= grant_idx;
      end
    end
  end

  assign o_resp_valid = (state_q == FULL);

endmodule
